abc_stim_scheduler: RTL and testbench
=====================================

Name: abc_stim_scheduler

Overview:
- Controller that shares the three-input let-test DUT port (a, b, c) among NUM_REQ stimulus requesters.
- Each requester asks for a burst: one 3-bit {a,b,c} pattern held for a programmed number of cycles.
- The block arbitrates round-robin, drives the burst, and inserts an idle gap after it.
- Each burst also reports how many cycles the DUT's let condition k (a && b) was true.
- Sits between bench stimulus agents and the DUT inputs, in the same clock domain as the DUT.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LEN_W, 8, width of the burst-length field.
- GAP_CYC, 2, idle cycles with a/b/c driven 0 after each burst (>=1).

Ports:
- clk  in  1  DUT clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; held until the matching gnt pulse.
- req_abc  in  3*NUM_REQ  per-requester pattern; bit2=a, bit1=b, bit0=c.
- req_len  in  LEN_W*NUM_REQ  per-requester burst length in cycles.
- gnt  out  NUM_REQ  one-hot, single-cycle pulse; request and its fields are accepted that cycle.
- done  out  NUM_REQ  one-hot, single-cycle pulse at the end of the owner's gap.
- a, b, c  out  1 each  registered DUT stimulus.
- busy  out  1  high in every state other than IDLE.
- k_cnt  out  LEN_W  number of burst cycles with a&&b; valid when done is high, held until the next grant.

Behaviour:
- Reset (asynchronous assert, synchronous release)
  - gnt, done = 0; a, b, c = 0; busy = 0; k_cnt = 0.
  - FSM = IDLE; round-robin pointer = 0.
- FSM states: IDLE, DRIVE, GAP, FIN.
- IDLE
  - If any req bit is set: select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Pulse gnt for that requester; latch its pattern and length; set pointer = selected+1 (mod NUM_REQ); clear k_cnt.
  - Next state is DRIVE, or GAP if the latched length is 0.
  - With no request, remain in IDLE with a/b/c = 0.
- DRIVE
  - a/b/c = latched pattern for exactly len cycles.
  - First driven cycle is the cycle after gnt, so grant-to-stimulus latency is 1.
  - k_cnt increments each DRIVE cycle where pattern a&b = 1; it saturates at its maximum value.
  - After the len-th cycle, go to GAP.
- GAP
  - a/b/c = 0 for GAP_CYC cycles, then go to FIN.
- FIN
  - One cycle: done pulses for the owner, k_cnt is valid, then return to IDLE.
  - Minimum turnaround is therefore 1 IDLE cycle between bursts; no back-to-back grants.
- req deasserted mid-burst: ignored; the burst completes.
- req_abc/req_len changes after gnt: ignored, because the values were latched at grant.
- Reset asserted mid-burst: outputs go to 0 immediately; no done is issued for the aborted burst.
- len = 2^LEN_W-1: legal; k_cnt can reach its maximum with no overflow.

Optional Feature:
- Macro: ABC_STIM_PRIO0_EN.
- Defined: requester 0 has strict priority. If req[0] is set in IDLE it wins regardless of the pointer, and the pointer is left unchanged; other requesters rotate round-robin among themselves.
- Undefined: pure round-robin as described above.

Decomposition:
- Package abc_stim_pkg:
  - state enum {IDLE, DRIVE, GAP, FIN};
  - abc_t packed struct {a, b, c};
  - default constants for NUM_REQ, LEN_W, GAP_CYC.
- Sub-module rr_arbiter, parameterised by NUM_REQ:
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and encoded index;
  - contains the ABC_STIM_PRIO0_EN masking.
- FSM, counters and output registers stay in abc_stim_scheduler.

Test Plan:
- Single burst: after reset, req[1]=1, req_abc[1]=3'b110, len=3.
  - gnt[1] at cycle t.
  - a=1, b=1, c=0 at cycles t+1..t+3; zeros at t+4..t+5.
  - done[1] at t+6 with k_cnt=3.
- Round-robin: req=4'b1111 held continuously.
  - Grants occur in order 0,1,2,3,0.
  - Each done precedes the next gnt by 1 cycle.
- Zero length: req[2], len=0.
  - gnt[2], then GAP only (a/b/c stay 0), done[2] 3 cycles after gnt, k_cnt=0.
- k counting: pattern 3'b101, len=5 -> k_cnt=0; pattern 3'b111, len=255 -> k_cnt=255 with no wrap.
- Mid-burst reset: drop rst_n during DRIVE.
  - a/b/c and busy go to 0 asynchronously; no done is pulsed.
  - After release, a pending request is granted with pointer=0.
- ABC_STIM_PRIO0_EN defined, req=4'b1001 held.
  - gnt[0] is issued on every grant; with req[0] then dropped, gnt[3] follows.

Source files
------------

// File: rtl/abc_stim_pkg.sv
// Shared types and default sizing for the a/b/c stimulus scheduler.
// Used by abc_stim_scheduler and its round-robin arbiter.
package abc_stim_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_GAP_CYC = 2;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP,
        FIN
    } state_t;

    // Field order matches the requester encoding: bit2=a, bit1=b, bit0=c.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
    } abc_t;

endpackage

// File: rtl/abc_stim_scheduler_rr_arbiter.sv
// Round-robin requester select starting at a rotating pointer.
// With ABC_STIM_PRIO0_EN defined, requester 0 wins outright and asks the caller to keep the pointer.
module rr_arbiter
    import abc_stim_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               valid,
    output logic               hold_ptr
);

    logic [PTR_W-1:0] cand;

    // Scan from the pointer upward, wrapping, and take the first requester found.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        valid    = 1'b0;
        hold_ptr = 1'b0;
        cand     = '0;
        if (en) begin
`ifdef ABC_STIM_PRIO0_EN
            if (req[0]) begin
                valid    = 1'b1;
                hold_ptr = 1'b1;
                idx      = '0;
            end else
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
                if (!valid && req[cand]) begin
                    valid = 1'b1;
                    idx   = cand;
                end
            end
            if (valid) begin
                gnt = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/abc_stim_scheduler.sv
// Shares the DUT a/b/c inputs among requesters: grant, hold a pattern for len cycles, idle gap, done.
// Optional build macro ABC_STIM_PRIO0_EN gives requester 0 strict priority (see rr_arbiter).
module abc_stim_scheduler
    import abc_stim_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [3*NUM_REQ-1:0]     req_abc,
    input  logic [LEN_W*NUM_REQ-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     a,
    output logic                     b,
    output logic                     c,
    output logic                     busy,
    output logic [LEN_W-1:0]         k_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int CNT_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;

    state_t           state, state_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic [PTR_W-1:0] own, own_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    abc_t             pat, pat_n;
    abc_t             abc_q, abc_n;
    logic [LEN_W-1:0] k_q, k_n;

    abc_t             req_pat  [NUM_REQ];
    logic [LEN_W-1:0] req_lens [NUM_REQ];

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               arb_hold;
    logic               arb_en;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_pat[i]  = abc_t'(req_abc[3*i +: 3]);
        assign req_lens[i] = req_len[LEN_W*i +: LEN_W];
    end

    // Gating with rst_n keeps gnt low while reset is held, since IDLE is the reset state.
    assign arb_en = (state == IDLE) && rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req      (req),
        .ptr      (ptr),
        .en       (arb_en),
        .gnt      (arb_gnt),
        .idx      (arb_idx),
        .valid    (arb_valid),
        .hold_ptr (arb_hold)
    );

    // Next-state, counters and next stimulus; cnt counts remaining cycles of DRIVE or GAP.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        own_n   = own;
        cnt_n   = cnt;
        pat_n   = pat;
        abc_n   = '0;
        k_n     = k_q;
        done    = '0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    own_n = arb_idx;
                    pat_n = req_pat[arb_idx];
                    k_n   = '0;
                    if (!arb_hold) begin
                        ptr_n = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    end
                    if (req_lens[arb_idx] == '0) begin
                        state_n = GAP;
                        cnt_n   = CNT_W'(GAP_CYC - 1);
                    end else begin
                        state_n = DRIVE;
                        cnt_n   = CNT_W'(req_lens[arb_idx]) - 1'b1;
                        abc_n   = req_pat[arb_idx];
                    end
                end
            end
            DRIVE: begin
                if (pat.a && pat.b && (k_q != '1)) begin
                    k_n = k_q + 1'b1;
                end
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = CNT_W'(GAP_CYC - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                    abc_n = pat;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = FIN;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            FIN: begin
                done    = NUM_REQ'(1) << own;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            own   <= '0;
            cnt   <= '0;
            pat   <= '0;
            abc_q <= '0;
            k_q   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            own   <= own_n;
            cnt   <= cnt_n;
            pat   <= pat_n;
            abc_q <= abc_n;
            k_q   <= k_n;
        end
    end

    assign gnt   = arb_gnt;
    assign busy  = (state != IDLE);
    assign a     = abc_q.a;
    assign b     = abc_q.b;
    assign c     = abc_q.c;
    assign k_cnt = k_q;

endmodule

// File: tb/tb_abc_stim_scheduler.sv
// Directed bench for abc_stim_scheduler: single/zero-length/long bursts, rotation, mid-burst reset.
// The strict-priority section only runs when ABC_STIM_PRIO0_EN is defined.
module tb_abc_stim_scheduler;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;
    localparam int GAP_CYC = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req = '0;
    logic [3*NUM_REQ-1:0]     req_abc = '0;
    logic [LEN_W*NUM_REQ-1:0] req_len = '0;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     a, b, c;
    logic                     busy;
    logic [LEN_W-1:0]         k_cnt;

    int total = 0;
    int bad   = 0;

    abc_stim_scheduler #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_abc (req_abc),
        .req_len (req_len),
        .gnt     (gnt),
        .done    (done),
        .a       (a),
        .b       (b),
        .c       (c),
        .busy    (busy),
        .k_cnt   (k_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [2:0] abc, input logic [7:0] len);
        req_abc[3*r +: 3] = abc;
        req_len[8*r +: 8] = len;
        req[r]            = 1'b1;
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        req     = '0;
        req_abc = '0;
        req_len = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_abc", {a, b, c}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_kcnt", k_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        checkOutput("idle_reached", busy, 0);
    endtask

    // Called at a negedge with the scheduler idle; returns at a negedge after the burst.
    task automatic runBurst(input int r, input logic [2:0] abc, input logic [7:0] len,
                            input logic [7:0] expk);
        logic [3:0] oh;
        oh = 4'b0001 << r;
        applyStimulus(r, abc, len);
        #1;
        checkOutput("burst_gnt", gnt, oh);
        @(posedge clk);
        #1;
        req[r]            = 1'b0;
        req_abc[3*r +: 3] = ~abc;
        req_len[8*r +: 8] = len + 8'd7;
        for (int i = 0; i < int'(len); i++) begin
            @(negedge clk);
            checkOutput("drive_abc", {a, b, c}, abc);
            checkOutput("drive_busy", busy, 1);
        end
        for (int g = 0; g < GAP_CYC; g++) begin
            @(negedge clk);
            checkOutput("gap_abc", {a, b, c}, 0);
            checkOutput("gap_done", done, 0);
        end
        @(negedge clk);
        checkOutput("fin_done", done, oh);
        checkOutput("fin_kcnt", k_cnt, expk);
        @(negedge clk);
        checkOutput("post_busy", busy, 0);
        checkOutput("post_done", done, 0);
        checkOutput("post_kcnt_held", k_cnt, expk);
    endtask

    initial begin
        logic [3:0] order [5];
        int n;
        int cyc;
        int lastDone;

        $display("[TB] start");
        doReset();

        runBurst(1, 3'b110, 8'd3, 8'd3);
        runBurst(2, 3'b110, 8'd0, 8'd0);
        runBurst(0, 3'b101, 8'd5, 8'd0);
        runBurst(3, 3'b111, 8'd255, 8'd255);

        // Rotation with every requester held high.
        doReset();
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int r = 0; r < NUM_REQ; r++) begin
            applyStimulus(r, 3'b011, 8'd1);
        end
        n = 0;
        cyc = 0;
        lastDone = -100;
        while (n < 5 && cyc < 100) begin
            #1;
            if (done != 0) lastDone = cyc;
            if (gnt != 0) begin
                checkOutput("rr_order", gnt, order[n]);
                if (n > 0) checkOutput("rr_turnaround", cyc - lastDone, 1);
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("rr_count", n, 5);
        req = '0;
        waitIdle();

        // Reset in the middle of a drive phase.
        doReset();
        applyStimulus(2, 3'b111, 8'd10);
        #1;
        checkOutput("mid_gnt", gnt, 4'b0100);
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_drive_abc", {a, b, c}, 3'b111);
        applyStimulus(1, 3'b010, 8'd2);
        applyStimulus(3, 3'b001, 8'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_abc", {a, b, c}, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_gnt", gnt, 0);
        checkOutput("mid_rst_kcnt", k_cnt, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("mid_rst_done", done, 0);
        end
        rst_n = 1'b1;
        #1;
        checkOutput("mid_release_gnt", gnt, 4'b0010);
        @(posedge clk);
        #1;
        req = '0;
        waitIdle();

`ifdef ABC_STIM_PRIO0_EN
        doReset();
        applyStimulus(0, 3'b100, 8'd1);
        applyStimulus(3, 3'b001, 8'd1);
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 100) begin
            #1;
            if (gnt != 0) begin
                checkOutput("prio_gnt0", gnt, 4'b0001);
                n++;
                if (n == 3) begin
                    @(posedge clk);
                    #1;
                    req[0] = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("prio_count", n, 3);
        n = 0;
        cyc = 0;
        while (n < 1 && cyc < 100) begin
            #1;
            if (gnt != 0) begin
                checkOutput("prio_gnt3", gnt, 4'b1000);
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("prio_gnt3_seen", n, 1);
        req = '0;
        waitIdle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
